ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter: EXC_CODE_OV, default 5'd12, the MIPS Cause.ExcCode for arithmetic overflow.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: stall  in  1  hold MEM register contents (downstream not ready).
REQ-005 SHALL have port: flush  in  1  replace the incoming EX instruction with a bubble.
REQ-006 SHALL have port: ex_valid  in  1  EX slot holds a real instruction.
REQ-007 SHALL have port: ex_pc  in  32  PC of the EX instruction.
REQ-008 SHALL have port: ex_alu_out  in  32  ALU result d_out.
REQ-009 SHALL have port: ex_zero  in  1  ALU zero_flag (operands equal).
REQ-010 SHALL have port: ex_overflow  in  1  ALU EXP_overflow.
REQ-011 SHALL have port: ex_ov_trap  in  1  instruction traps on overflow (add/sub/addi); 0 for addu/subu/ori.
REQ-012 SHALL have port: ex_store_data  in  32  rt value for stores.
REQ-013 SHALL have port: ex_wreg  in  5  destination register.
REQ-014 SHALL have port: ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits.
REQ-015 SHALL have port: mem_valid, mem_pc, mem_alu_out, mem_zero, mem_store_data, mem_wreg, mem_reg_write, mem_mem_read, mem_mem_write  out  matching widths  registered MEM-stage copies.
REQ-016 SHALL have port: exc_req  out  1  overflow exception pending to CP0.
REQ-017 SHALL have port: exc_epc  out  32  PC of the faulting instruction.
REQ-018 SHALL have port: exc_cause  out  5  ExcCode; equals EXC_CODE_OV while exc_req=1, else 0.
REQ-019 SHALL have port: exc_ack  in  1  CP0 has taken the exception.
REQ-020 SHALL have port: exc_count  out  8  number of overflow traps taken, saturating.

Function
REQ-021 SHALL implement a two-state FSM: RUN and TRAP.
REQ-022 In RUN, priority per edge SHALL be flush > trap > stall > load.
REQ-023 A trap condition SHALL be ex_valid & ex_ov_trap & ex_overflow & !stall & !flush.
REQ-024 On load, all mem_* outputs SHALL take their ex_* inputs one cycle later; latency is 1 cycle.
REQ-025 On flush (not stall-gated), mem_valid, mem_reg_write, mem_mem_read and mem_mem_write SHALL clear to 0; data fields are don't-care.
REQ-026 On stall without flush, every mem_* output SHALL hold its value.
REQ-027 On trap: insert a bubble as in REQ-025 (the faulting write is suppressed), capture exc_epc<=ex_pc, set exc_req=1, increment exc_count (saturate at 255), go to TRAP.
REQ-028 In TRAP: outputs stay a bubble; stall, flush and ex_* are ignored; exc_req and exc_epc hold.
REQ-029 In TRAP with exc_ack=1: clear exc_req, return to RUN; the EX instruction in that same cycle is not loaded (bubble).
REQ-030 exc_ack in RUN SHALL be ignored.
REQ-031 ex_overflow with ex_ov_trap=0 SHALL load normally; the wrapped result passes through.
REQ-032 mem_zero SHALL be passed through unmodified; it is not qualified by valid.

Reset
REQ-033 On rst=1 at an edge, state SHALL go to RUN and mem_valid, all control outputs, exc_req, exc_cause and exc_count SHALL go to 0; mem_pc, mem_alu_out, mem_store_data, mem_wreg and exc_epc SHALL go to 0.
REQ-034 rst SHALL override stall, flush, exc_ack and a pending TRAP in the same cycle.

Structure
REQ-035 A shared package SHALL hold the EXC_CODE_OV constant, the RUN/TRAP state encoding and the data/register-index width constants.
REQ-036 A generic enable/clear register sub-module, pipe_reg (parameter WIDTH), SHALL implement the payload flops; the FSM and exception logic SHALL stay in ex_mem_reg.

Verification
REQ-037 Load: ex_valid=1, ex_alu_out=0x00000005, ex_wreg=8, ex_reg_write=1 -> next cycle mem_alu_out=5, mem_wreg=8, mem_reg_write=1.
REQ-038 Trap: ex_pc=0x00400010, ex_alu_out=0x80000000, ex_overflow=1, ex_ov_trap=1 -> mem_reg_write=0, exc_req=1, exc_epc=0x00400010, exc_cause=12, exc_count=1; it holds until exc_ack, and returns to RUN one cycle after the ack.
REQ-039 Unsigned op: same operands with ex_ov_trap=0 -> mem_alu_out=0x80000000, mem_reg_write=1, exc_req=0.
REQ-040 Stall/flush: stall=1 for 3 cycles -> outputs frozen; flush=1 together with stall=1 -> bubble; overflow together with flush -> no trap, exc_count unchanged.
REQ-041 Saturation/reset: 256 traps -> exc_count=255; rst=1 while in TRAP -> exc_req=0, state RUN, exc_count=0.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// EX/MEM pipeline register shared definitions.
// Holds widths, the overflow ExcCode, FSM encoding and the payload bundles.
package ex_mem_reg_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int EXC_W  = 5;
    localparam int CNT_W  = 8;

    localparam logic [EXC_W-1:0] EXC_CODE_OV_DEF = 5'd12;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] alu_out;
        logic              zero;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  wreg;
    } mem_data_t;

    // Saturating increment for the trap counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ex_mem_reg_pipe_reg.sv
// Generic enable/clear register used for the EX/MEM payload flops.
// Ports: i_clk, i_rst (sync, high), i_en load, i_clr zero (beats i_en), i_d, o_q.
module pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with overflow-trap handshake to CP0.
// Ports: clk/rst, stall/flush, ex_* EX-stage inputs, mem_* registered MEM copies,
// exc_req/exc_epc/exc_cause/exc_count to CP0, exc_ack from CP0.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter logic [EXC_W-1:0] EXC_CODE_OV = EXC_CODE_OV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic              ex_zero,
    input  logic              ex_overflow,
    input  logic              ex_ov_trap,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_wreg,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_pc,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic              mem_zero,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_W-1:0]  mem_wreg,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              exc_req,
    output logic [DATA_W-1:0] exc_epc,
    output logic [EXC_W-1:0]  exc_cause,
    input  logic              exc_ack,
    output logic [CNT_W-1:0]  exc_count
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_run;
    logic              w_trap;
    logic              w_bubble;
    logic              w_ld_ctrl;
    logic              w_ld_data;
    logic              w_exc_set;
    logic              w_exc_clr;
    logic              r_exc_req;
    logic [DATA_W-1:0] r_exc_epc;
    logic [CNT_W-1:0]  r_exc_cnt;
    mem_ctrl_t         w_ctrl_d;
    mem_ctrl_t         w_ctrl_q;
    mem_data_t         w_data_d;
    mem_data_t         w_data_q;

    assign w_run  = (r_state == ST_RUN);
    assign w_trap = w_run & ex_valid & ex_ov_trap & ex_overflow
                  & ~stall & ~flush;

    // TRAP keeps the control bits cleared every cycle, including the
    // ack cycle, so the EX instruction seen then is dropped.
    assign w_bubble  = ~w_run | flush | w_trap;
    assign w_ld_ctrl = w_run & ~stall;
    assign w_ld_data = w_run & ~stall & ~w_bubble;

    assign w_ctrl_d = '{
        valid:     ex_valid,
        reg_write: ex_reg_write,
        mem_read:  ex_mem_read,
        mem_write: ex_mem_write
    };

    assign w_data_d = '{
        pc:         ex_pc,
        alu_out:    ex_alu_out,
        zero:       ex_zero,
        store_data: ex_store_data,
        wreg:       ex_wreg
    };

    pipe_reg #(
        .WIDTH($bits(mem_ctrl_t))
    ) u_ctrl (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (w_ld_ctrl),
        .i_clr (w_bubble),
        .i_d   (w_ctrl_d),
        .o_q   (w_ctrl_q)
    );

    pipe_reg #(
        .WIDTH($bits(mem_data_t))
    ) u_data (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (w_ld_data),
        .i_clr (1'b0),
        .i_d   (w_data_d),
        .o_q   (w_data_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exc_set   = 1'b0;
        w_exc_clr   = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (w_trap) begin
                    w_state_nxt = ST_TRAP;
                    w_exc_set   = 1'b1;
                end
            end
            ST_TRAP: begin
                if (exc_ack) begin
                    w_state_nxt = ST_RUN;
                    w_exc_clr   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc_req <= 1'b0;
            r_exc_epc <= '0;
            r_exc_cnt <= '0;
        end else if (w_exc_set) begin
            r_exc_req <= 1'b1;
            r_exc_epc <= ex_pc;
            r_exc_cnt <= sat_inc(r_exc_cnt);
        end else if (w_exc_clr) begin
            r_exc_req <= 1'b0;
        end
    end

    assign mem_valid      = w_ctrl_q.valid;
    assign mem_reg_write  = w_ctrl_q.reg_write;
    assign mem_mem_read   = w_ctrl_q.mem_read;
    assign mem_mem_write  = w_ctrl_q.mem_write;
    assign mem_pc         = w_data_q.pc;
    assign mem_alu_out    = w_data_q.alu_out;
    assign mem_zero       = w_data_q.zero;
    assign mem_store_data = w_data_q.store_data;
    assign mem_wreg       = w_data_q.wreg;

    assign exc_req   = r_exc_req;
    assign exc_epc   = r_exc_epc;
    assign exc_cause = r_exc_req ? EXC_CODE_OV : '0;
    assign exc_count = r_exc_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed table, corner sequences,
// and random stimulus against a behavioural model.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_valid;
    logic [31:0] ex_pc, ex_alu_out, ex_store_data;
    logic        ex_zero, ex_overflow, ex_ov_trap;
    logic [4:0]  ex_wreg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        mem_valid, mem_zero, mem_reg_write, mem_mem_read, mem_mem_write;
    logic [31:0] mem_pc, mem_alu_out, mem_store_data;
    logic [4:0]  mem_wreg;
    logic        exc_req, exc_ack;
    logic [31:0] exc_epc;
    logic [4:0]  exc_cause;
    logic [7:0]  exc_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_out(ex_alu_out),
        .ex_zero(ex_zero), .ex_overflow(ex_overflow), .ex_ov_trap(ex_ov_trap),
        .ex_store_data(ex_store_data), .ex_wreg(ex_wreg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_out(mem_alu_out),
        .mem_zero(mem_zero), .mem_store_data(mem_store_data),
        .mem_wreg(mem_wreg), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .exc_req(exc_req), .exc_epc(exc_epc), .exc_cause(exc_cause),
        .exc_ack(exc_ack), .exc_count(exc_count)
    );

    typedef struct {
        logic        rst, stall, flush, valid;
        logic [31:0] pc, alu;
        logic        zero, ov, ovt;
        logic [31:0] sd;
        logic [4:0]  wreg;
        logic        rw, mr, mw, ack;
    } vin_t;

    typedef struct {
        vin_t        i;
        logic        e_valid, e_rw;
        logic [31:0] e_alu;
        logic [4:0]  e_wreg;
        logic        e_chkd;
        logic        e_req;
        logic [31:0] e_epc;
        logic [7:0]  e_cnt;
    } vec_t;

    // Behavioural model of what MEM/CP0 should see.
    bit          m_trap;
    logic        m_valid, m_rw, m_mr, m_mw, m_zero, m_req;
    logic [31:0] m_pc, m_alu, m_sd, m_epc;
    logic [4:0]  m_wreg;
    int          m_cnt;
    bit          m_dk;

    function automatic vin_t vz();
        vin_t v;
        v.rst = 0; v.stall = 0; v.flush = 0; v.valid = 0;
        v.pc = 0; v.alu = 0; v.zero = 0; v.ov = 0; v.ovt = 0;
        v.sd = 0; v.wreg = 0; v.rw = 0; v.mr = 0; v.mw = 0; v.ack = 0;
        return v;
    endfunction

    function automatic vin_t vld(logic [31:0] pc, logic [31:0] alu,
                                 logic [4:0] wr, logic ov, logic ovt);
        vin_t v = vz();
        v.valid = 1; v.pc = pc; v.alu = alu; v.wreg = wr;
        v.rw = 1; v.ov = ov; v.ovt = ovt; v.sd = alu ^ 32'h5a5a_5a5a;
        v.zero = alu[0];
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic bubble();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_dk = 0;
    endtask

    task automatic model(input vin_t v);
        if (v.rst) begin
            m_trap = 0; bubble(); m_req = 0; m_epc = 0; m_cnt = 0;
            m_pc = 0; m_alu = 0; m_sd = 0; m_wreg = 0; m_zero = 0; m_dk = 1;
        end else if (m_trap) begin
            bubble();
            if (v.ack) begin
                m_req = 0; m_trap = 0;
            end
        end else if (v.flush) begin
            bubble();
        end else if (v.valid && v.ovt && v.ov && !v.stall) begin
            bubble();
            m_req = 1; m_epc = v.pc; m_trap = 1;
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end else if (!v.stall) begin
            m_valid = v.valid; m_rw = v.rw; m_mr = v.mr; m_mw = v.mw;
            m_pc = v.pc; m_alu = v.alu; m_sd = v.sd; m_wreg = v.wreg;
            m_zero = v.zero; m_dk = 1;
        end
    endtask

    task automatic check_model();
        cmp("valid", 32'(mem_valid), 32'(m_valid));
        cmp("reg_write", 32'(mem_reg_write), 32'(m_rw));
        cmp("mem_read", 32'(mem_mem_read), 32'(m_mr));
        cmp("mem_write", 32'(mem_mem_write), 32'(m_mw));
        cmp("exc_req", 32'(exc_req), 32'(m_req));
        cmp("exc_cause", 32'(exc_cause), m_req ? 32'd12 : 32'd0);
        cmp("exc_epc", exc_epc, m_epc);
        cmp("exc_count", 32'(exc_count), 32'(m_cnt));
        if (m_dk) begin
            cmp("pc", mem_pc, m_pc);
            cmp("alu_out", mem_alu_out, m_alu);
            cmp("store_data", mem_store_data, m_sd);
            cmp("wreg", 32'(mem_wreg), 32'(m_wreg));
            cmp("zero", 32'(mem_zero), 32'(m_zero));
        end
    endtask

    task automatic drive(input vin_t v);
        rst = v.rst; stall = v.stall; flush = v.flush; ex_valid = v.valid;
        ex_pc = v.pc; ex_alu_out = v.alu; ex_zero = v.zero;
        ex_overflow = v.ov; ex_ov_trap = v.ovt; ex_store_data = v.sd;
        ex_wreg = v.wreg; ex_reg_write = v.rw; ex_mem_read = v.mr;
        ex_mem_write = v.mw; exc_ack = v.ack;
    endtask

    task automatic apply(input vin_t v);
        drive(v);
        @(posedge clk);
        model(v);
        #1;
        check_model();
    endtask

    function automatic vec_t mkv(vin_t i, logic ev, logic erw,
                                 logic [31:0] ea, logic [4:0] ew, logic ed,
                                 logic er, logic [31:0] ee, logic [7:0] ec);
        vec_t t;
        t.i = i; t.e_valid = ev; t.e_rw = erw; t.e_alu = ea; t.e_wreg = ew;
        t.e_chkd = ed; t.e_req = er; t.e_epc = ee; t.e_cnt = ec;
        return t;
    endfunction

    vec_t tbl[13];

    initial begin
        vin_t v;
        localparam logic [31:0] EPC = 32'h0040_0010;

        drive(vz());
        @(negedge clk);

        v = vz(); v.rst = 1;
        tbl[0] = mkv(v, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[1] = mkv(vld(32'h0040_0000, 32'h5, 5'd8, 0, 0),
                     1, 1, 32'h5, 5'd8, 1, 0, 0, 0);
        tbl[2] = mkv(vld(EPC, 32'h8000_0000, 5'd9, 1, 0),
                     1, 1, 32'h8000_0000, 5'd9, 1, 0, 0, 0);
        tbl[3] = mkv(vld(EPC, 32'h8000_0000, 5'd9, 1, 1),
                     0, 0, 0, 0, 0, 1, EPC, 1);
        tbl[4] = mkv(vld(32'h0040_0014, 32'h1, 5'd2, 0, 0),
                     0, 0, 0, 0, 0, 1, EPC, 1);
        v = vld(32'h0040_0018, 32'h2, 5'd2, 0, 0); v.ack = 1;
        tbl[5] = mkv(v, 0, 0, 0, 0, 0, 0, EPC, 1);
        tbl[6] = mkv(vld(32'h0040_001c, 32'h7, 5'd3, 0, 0),
                     1, 1, 32'h7, 5'd3, 1, 0, EPC, 1);
        v = vld(32'h0040_0020, 32'h9, 5'd4, 0, 0); v.stall = 1;
        tbl[7] = mkv(v, 1, 1, 32'h7, 5'd3, 1, 0, EPC, 1);
        v.alu = 32'hA; v.ov = 1; v.ovt = 1;
        tbl[8] = mkv(v, 1, 1, 32'h7, 5'd3, 1, 0, EPC, 1);
        v.alu = 32'hB;
        tbl[9] = mkv(v, 1, 1, 32'h7, 5'd3, 1, 0, EPC, 1);
        v.flush = 1;
        tbl[10] = mkv(v, 0, 0, 0, 0, 0, 0, EPC, 1);
        v = vld(32'h0040_0030, 32'h8000_0000, 5'd5, 1, 1); v.flush = 1;
        tbl[11] = mkv(v, 0, 0, 0, 0, 0, 0, EPC, 1);
        v = vld(32'h0040_0034, 32'h11, 5'd6, 0, 0); v.ack = 1;
        tbl[12] = mkv(v, 1, 1, 32'h11, 5'd6, 1, 0, EPC, 1);

        foreach (tbl[k]) begin
            apply(tbl[k].i);
            cmp($sformatf("t%0d.valid", k), 32'(mem_valid), 32'(tbl[k].e_valid));
            cmp($sformatf("t%0d.rw", k), 32'(mem_reg_write), 32'(tbl[k].e_rw));
            cmp($sformatf("t%0d.req", k), 32'(exc_req), 32'(tbl[k].e_req));
            cmp($sformatf("t%0d.epc", k), exc_epc, tbl[k].e_epc);
            cmp($sformatf("t%0d.cnt", k), 32'(exc_count), 32'(tbl[k].e_cnt));
            if (tbl[k].e_chkd) begin
                cmp($sformatf("t%0d.alu", k), mem_alu_out, tbl[k].e_alu);
                cmp($sformatf("t%0d.wreg", k), 32'(mem_wreg), 32'(tbl[k].e_wreg));
            end
        end

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            v.rst   = ($urandom_range(0, 199) == 0);
            v.stall = ($urandom_range(0, 3) == 0);
            v.flush = ($urandom_range(0, 7) == 0);
            v.valid = ($urandom_range(0, 3) != 0);
            v.pc    = $urandom;
            v.alu   = $urandom;
            v.sd    = $urandom;
            v.zero  = 1'($urandom);
            v.ov    = ($urandom_range(0, 3) == 0);
            v.ovt   = 1'($urandom);
            v.wreg  = 5'($urandom);
            v.rw    = 1'($urandom);
            v.mr    = 1'($urandom);
            v.mw    = 1'($urandom);
            v.ack   = ($urandom_range(0, 2) == 0);
            apply(v);
        end

        // Saturation: 256 trap/ack pairs.
        v = vz(); v.rst = 1;
        apply(v);
        for (int n = 0; n < 256; n++) begin
            apply(vld(32'h1000 + 32'(n * 4), 32'h8000_0000, 5'd7, 1, 1));
            v = vz(); v.ack = 1;
            apply(v);
        end
        cmp("sat.cnt", 32'(exc_count), 32'd255);

        // Reset wins over a pending TRAP.
        apply(vld(32'h2000, 32'h7fff_ffff, 5'd7, 1, 1));
        cmp("trap.req", 32'(exc_req), 32'd1);
        cmp("trap.cnt_hold", 32'(exc_count), 32'd255);
        v = vz(); v.rst = 1; v.ack = 0; v.stall = 1; v.flush = 1;
        apply(v);
        cmp("rst.req", 32'(exc_req), 32'd0);
        cmp("rst.cnt", 32'(exc_count), 32'd0);
        cmp("rst.cause", 32'(exc_cause), 32'd0);
        apply(vld(32'h3000, 32'h42, 5'd1, 0, 0));
        cmp("rst.run", 32'(mem_valid), 32'd1);
        cmp("rst.alu", mem_alu_out, 32'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
